// File: rtl/dmem_if.sv
// CPU data-port bus between the MEM stage (master) and the data-memory
// controller (slave). Handshake: the master holds req with ren/we/daddr/dwdata
// for the access; the slave accepts it in IDLE and raises dstall until the
// access completes. dstall low while the access is in DONE means drdata/derr
// are valid on this cycle and the master advances on the next rising edge.
interface dmem_if;
    logic        req;
    logic        ren;
    logic [3:0]  we;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] drdata;
    logic        dstall;
    logic        derr;
    logic [15:0] nstall;

    modport master (
        output req, ren, we, daddr, dwdata,
        input  drdata, dstall, derr, nstall
    );

    modport slave (
        input  req, ren, we, daddr, dwdata,
        output drdata, dstall, derr, nstall
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: accepts one load/store, stalls the core for
// LATENCY cycles, then commits a byte-enabled write into a word array and
// returns the pre-write word. Out-of-range accesses suppress the write and
// flag derr. dbg_state exposes the FSM state (IDLE=0, WAIT=1, DONE=2).
module dmem_ctrl #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst,
    dmem_if.slave      bus,
    output logic [1:0] dbg_state
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_nx;
    logic [3:0]  cnt;
    logic [29:0] lat_idx;
    logic [3:0]  lat_we;
    logic [31:0] lat_wdata;

    logic        act;
    logic        stall_raw;
    logic        go_done;
    logic [29:0] c_idx;
    logic [3:0]  c_we;
    logic [31:0] c_wdata;
    logic        in_range;

    logic [31:0] drdata_q;
    logic        derr_q;
    logic [15:0] nstall_q;
    logic [31:0] mem [DEPTH];

    assign act = bus.req & (bus.ren | (|bus.we));

    // Stall while a new access is being accepted or while waiting it out.
    assign stall_raw = ((state == S_IDLE) & act) | (state == S_WAIT);

    // Reset forces the stall low immediately, even with req held high.
    assign bus.dstall = rst & stall_raw;

    // With LATENCY==1 the commit happens on the accept edge itself, before the
    // request has been latched, so the commit operands come straight from the
    // bus in IDLE and from the latched copy otherwise.
    assign c_idx    = (state == S_IDLE) ? 30'(bus.daddr >> 2) : lat_idx;
    assign c_we     = (state == S_IDLE) ? bus.we : lat_we;
    assign c_wdata  = (state == S_IDLE) ? bus.dwdata : lat_wdata;
    assign in_range = (c_idx < 30'(DEPTH));

    // Next-state decode; go_done marks the edge that enters DONE.
    always_comb begin
        state_nx = state;
        go_done  = 1'b0;
        case (state)
            S_IDLE: begin
                if (act) begin
                    if (LATENCY == 1) begin
                        state_nx = S_DONE;
                        go_done  = 1'b1;
                    end else begin
                        state_nx = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd1) begin
                    state_nx = S_DONE;
                    go_done  = 1'b1;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // FSM state, wait counter and the latched request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            lat_idx   <= '0;
            lat_we    <= '0;
            lat_wdata <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && act) begin
                cnt       <= 4'(LATENCY - 1);
                lat_idx   <= 30'(bus.daddr >> 2);
                lat_we    <= bus.we;
                lat_wdata <= bus.dwdata;
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Commit: read-before-write into drdata, then the byte-lane write. The
    // array itself is never reset, and a reset edge never commits, which is
    // what drops a pending store when reset lands mid-access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drdata_q <= '0;
            derr_q   <= 1'b0;
        end else begin
            derr_q <= 1'b0;
            if (go_done) begin
                if (in_range) begin
                    drdata_q <= mem[c_idx[AW-1:0]];
                    for (int k = 0; k < 4; k++) begin
                        if (c_we[k]) begin
                            mem[c_idx[AW-1:0]][8*k +: 8] <= c_wdata[8*k +: 8];
                        end
                    end
                end else begin
                    drdata_q <= '0;
                    derr_q   <= 1'b1;
                end
            end
        end
    end

    // Saturating count of stalled cycles since reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nstall_q <= '0;
        end else if (stall_raw && nstall_q != 16'hFFFF) begin
            nstall_q <= nstall_q + 16'd1;
        end
    end

    assign bus.drdata = drdata_q;
    assign bus.derr   = derr_q;
    assign bus.nstall = nstall_q;
    assign dbg_state  = state;

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller on the CPU data port. It accepts one load/store per request, holds the pipeline with `dstall` for a fixed number of wait states, and commits byte-enabled writes into an internal word array. It returns registered read data and flags out-of-range accesses. It sits directly downstream of the pipelined core's MEM stage and consumes `daddr`, `we` and `dwdata`. It returns `drdata`, plus the stall the core uses to freeze EX/MEM and MEM/WB.

## Interface
- `DEPTH`, 32: number of 32-bit words; the valid byte range is 0 .. 4*DEPTH-1.
- `LATENCY`, 2: stall cycles per access; legal range 1..15.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: one clock; reset is asynchronous and active-low.
- `req` input 1: the MEM stage holds a load or store.
- `ren` input 1: the access is a load.
- `we` input 4: byte write enables, already lane-aligned by the core.
- `daddr` input 32: byte address; bits [1:0] are ignored, so accesses are word-granular.
- `dwdata` input 32: write data, lane-aligned.
- `drdata` output 32: registered read word.
- `dstall` output 1: the core must not advance EX/MEM or MEM/WB.
- `derr` output 1: the completed access was out of range.
- `nstall` output 16: saturating count of stalled cycles since reset.

## Operation
- An access is active when `act = req & (ren | |we)`.
- FSM states are IDLE, WAIT and DONE; the encoding is free.
- IDLE
  - When `act` is high, latch `daddr[31:2]`, `we`, `dwdata` and `ren`, and load the counter with LATENCY-1.
  - If LATENCY==1, next state is DONE; otherwise next state is WAIT.
  - When `act` is low, stay in IDLE.
- WAIT: decrement the counter each cycle. When the counter reaches 1, next state is DONE.
- Edge entering DONE (commit)
  - Range check: the latched word index must be less than DEPTH.
  - In range: `drdata <= mem[idx]`, the pre-write contents (read-before-write). Then each byte lane k with `we[k]` set is written from `dwdata[8k+7:8k]`.
  - Out of range: the write is suppressed, `drdata <= 0`, `derr <= 1`.
- DONE
  - `dstall` is 0 and `drdata`/`derr` are valid; the core advances on this cycle's edge.
  - `req` is ignored in DONE because it still belongs to the completed access. Next state is always IDLE.
  - `derr` clears on leaving DONE.
- `dstall = (state==IDLE & act) | (state==WAIT)`. It is combinational from `req`/`ren`/`we` only in IDLE.
- Only the latched request is used once accepted; input changes in WAIT are ignored.
- `nstall` increments on every cycle with `dstall==1` and holds at 16'hFFFF.
- `ren` together with nonzero `we` is legal: the write is performed and `drdata` returns the old word.
- Memory contents are not cleared by reset.

## Timing
- Reset (asynchronous, `rst==0`)
  - State goes to IDLE, the counter to 0, `drdata=0`, `derr=0`, `nstall=0`.
  - `dstall` becomes 0 immediately while in reset, even if `req` is high.
- Reset mid-access: the pending write is dropped and the array is unchanged.
- Request first seen at cycle t:
  - `dstall` is 1 in cycles t .. t+LATENCY-1.
  - DONE is at t+LATENCY, with `dstall=0`.
  - Total occupancy is LATENCY+1 cycles.
- Back-to-back accesses: the earliest next acceptance is t+LATENCY+1, which is IDLE.
- Throughput: one access per LATENCY+1 cycles.
- A write is visible to a load accepted in the cycle immediately after DONE.

## Test plan
- Reset value: hold `rst=0` with `req=1`, `we=4'hF` → `dstall=0`, `drdata=0`, `derr=0`, `nstall=0`; release → access accepted next edge.
- Word write, then read (LATENCY=2):
  - Store `32'hDEADBEEF` to `0x10` with `we=4'hF` → `dstall` high exactly 2 cycles.
  - Load `0x10` → `drdata=32'hDEADBEEF` in its DONE cycle.
- Byte enables: over `0x10` (holding `32'hDEADBEEF`), store `32'h00AA0000` with `we=4'b0100` → later load returns `32'hDEAABEEF`.
- Read-before-write: `ren=1`, `we=4'hF`, `dwdata=32'h12345678` at `0x10` (holding `32'hDEAABEEF`) → `drdata=32'hDEAABEEF`; a following load returns `32'h12345678`.
- Out of range:
  - Store to `0x80` (DEPTH=32) → `derr=1` for one cycle in DONE, `drdata=0`; word 0 unchanged.
  - Load `0x7C` → `derr=0`.
- Reset mid-access and counter:
  - Assert `rst=0` during WAIT of a store to `0x20` → store dropped (`0x20` unchanged), state IDLE.
  - After 3 accesses at LATENCY=2 → `nstall=6`.
